uart_rx_unit: RTL and testbench

Serial receive side of the UART, the counterpart of the transmit unit. It recovers 8-bit frames from the serial line using 16x oversampling with mid-bit sampling. The baud rate and parity type use the same 2-bit codes the transmitter is configured with. It sits between the asynchronous line input and the system's parallel consumer, and reports the received byte plus parity and framing error status.

---
 rtl/uart_rx_unit.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_unit.sv
// rtl/uart_rx_unit.sv - 16x oversampled UART receiver with parity and framing checks
module uart_rx_unit #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_rx,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    output logic [7:0] data_out,
    output logic       parity_error,
    output logic       frame_error,
    output logic       active_flag,
    output logic       done_flag
);

    localparam int DIV_2400  = CLK_FREQ / (16 * 2400);
    localparam int DIV_4800  = CLK_FREQ / (16 * 4800);
    localparam int DIV_9600  = CLK_FREQ / (16 * 9600);
    localparam int DIV_19200 = CLK_FREQ / (16 * 19200);
    localparam int CW        = $clog2(DIV_2400 + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic          rx_meta;
    logic          rx_s;
    logic          rx_prev;
    logic [2:0]    state;
    logic [1:0]    baud_l;
    logic [1:0]    par_l;
    logic [CW-1:0] tick_cnt;
    logic [CW-1:0] div_m1;
    logic [3:0]    samp_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          par_bit;
    logic          done_save;
    logic          tick;
    logic          full_bit;
    logic          start_edge;
    logic          par_en;
    logic          par_err_calc;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= data_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Oversample divisor minus one, from the baud code latched at frame start
    always_comb begin
        div_m1 = CW'(DIV_9600 - 1);
        case (baud_l)
            2'b00:   div_m1 = CW'(DIV_2400 - 1);
            2'b01:   div_m1 = CW'(DIV_4800 - 1);
            2'b10:   div_m1 = CW'(DIV_9600 - 1);
            default: div_m1 = CW'(DIV_19200 - 1);
        endcase
    end

    assign start_edge  = rx_prev & ~rx_s;
    assign tick        = (tick_cnt == div_m1);
    assign full_bit    = tick && (samp_cnt == 4'd15);
    assign par_en      = (par_l == 2'b01) || (par_l == 2'b10);
    assign active_flag = (state != IDLE);

    // Odd parity wants an odd total of ones across data and parity bit, even wants even
    always_comb begin
        par_err_calc = 1'b0;
        case (par_l)
            2'b01:   par_err_calc = ~(^shift_reg ^ par_bit);
            2'b10:   par_err_calc = ^shift_reg ^ par_bit;
            default: par_err_calc = 1'b0;
        endcase
    end

    // Tick counter: free-runs 0..DIV-1 while a frame is in progress, parked at 0 in IDLE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (state == IDLE || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    // Frame FSM: mid-bit sampling, shift register, and result commit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            baud_l       <= 2'b00;
            par_l        <= 2'b00;
            samp_cnt     <= 4'd0;
            bit_cnt      <= 3'd0;
            shift_reg    <= 8'h00;
            par_bit      <= 1'b0;
            done_save    <= 1'b0;
            data_out     <= 8'h00;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            done_flag    <= 1'b0;
        end else begin
            if (state != IDLE && tick) begin
                samp_cnt <= samp_cnt + 4'd1;
            end
            case (state)
                IDLE: begin
                    samp_cnt <= 4'd0;
                    if (start_edge) begin
                        state     <= START;
                        baud_l    <= baud_rate;
                        par_l     <= parity_type;
                        done_save <= done_flag;
                        done_flag <= 1'b0;
                    end
                end
                START: begin
                    if (tick && samp_cnt == 4'd7) begin
                        samp_cnt <= 4'd0;
                        bit_cnt  <= 3'd0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            // False start: the frame never existed, so done_flag is restored
                            state     <= IDLE;
                            done_flag <= done_save;
                        end
                    end
                end
                DATA: begin
                    if (full_bit) begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= par_en ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (full_bit) begin
                        par_bit <= rx_s;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (full_bit) begin
                        data_out     <= shift_reg;
                        parity_error <= par_err_calc;
                        frame_error  <= ~rx_s;
                        done_flag    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// tb/tb_uart_rx_unit.sv - randomized self-checking bench for uart_rx_unit
module tb_uart_rx_unit;

    localparam int CLK_FREQ = 614400;
    localparam int BIT      = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       data_rx = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic [1:0] baud_rate = 2'b10;
    logic [7:0] data_out;
    logic       parity_error;
    logic       frame_error;
    logic       active_flag;
    logic       done_flag;

    int n_checks = 0;
    int n_pass   = 0;
    int act_cnt  = 0;

    uart_rx_unit #(.CLK_FREQ(CLK_FREQ)) dut (
        .clock        (clock),
        .reset        (reset),
        .data_rx      (data_rx),
        .parity_type  (parity_type),
        .baud_rate    (baud_rate),
        .data_out     (data_out),
        .parity_error (parity_error),
        .frame_error  (frame_error),
        .active_flag  (active_flag),
        .done_flag    (done_flag)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (active_flag) act_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: parity error from the count of ones in data plus parity bit
    function automatic logic exp_perr(input logic [7:0] d, input logic [1:0] pt, input logic pb);
        int ones;
        ones = $countones(d) + int'(pb);
        if (pt == 2'b01) return (ones % 2) == 0;
        if (pt == 2'b10) return (ones % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic has_parity(input logic [1:0] pt);
        return (pt == 2'b01) || (pt == 2'b10);
    endfunction

    task automatic drive_bit(input logic b, input int n);
        data_rx = b;
        repeat (n) @(negedge clock);
    endtask

    // Drives one full frame; optionally scrambles the config inputs mid-frame
    task automatic send_frame(input logic [7:0] d, input logic pb, input logic stop, input bit scramble);
        logic [1:0] pt;
        pt = parity_type;
        drive_bit(1'b0, BIT / 2);
        if (scramble) begin
            parity_type = 2'($urandom);
            baud_rate   = 2'($urandom);
        end
        drive_bit(1'b0, BIT / 2);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
        if (has_parity(pt)) drive_bit(pb, BIT);
        drive_bit(stop, BIT);
        data_rx = 1'b1;
        parity_type = pt;
        baud_rate   = 2'b10;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (active_flag && k < 300) begin
            @(negedge clock);
            k++;
        end
        check("idle_timeout", 32'(active_flag), 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        wait_idle();
        check({tag, "_data"}, 32'(data_out), 32'(d));
        check({tag, "_perr"}, 32'(parity_error), 32'(pe));
        check({tag, "_ferr"}, 32'(frame_error), 32'(fe));
        check({tag, "_done"}, 32'(done_flag), 32'd1);
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] pt;
        logic       pb;
        logic       stop;

        repeat (3) @(negedge clock);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_perr", 32'(parity_error), 32'd0);
        check("rst_ferr", 32'(frame_error), 32'd0);
        check("rst_active", 32'(active_flag), 32'd0);
        check("rst_done", 32'(done_flag), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // No parity, A5, with active-time measurement
        parity_type = 2'b00;
        act_cnt = 0;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check_frame("np_a5", 8'hA5, 1'b0, 1'b0);
        check("np_active_len", 32'(act_cnt >= 600 && act_cnt <= 616), 32'd1);

        // Even parity, good then bad parity bit
        parity_type = 2'b10;
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
        check_frame("even_ok", 8'h0F, exp_perr(8'h0F, 2'b10, 1'b0), 1'b0);
        send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
        check_frame("even_bad", 8'h0F, exp_perr(8'h0F, 2'b10, 1'b1), 1'b0);

        // Odd parity, good frame then a low stop bit
        parity_type = 2'b01;
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        check_frame("odd_ok", 8'h01, exp_perr(8'h01, 2'b01, 1'b0), 1'b0);
        send_frame(8'h01, 1'b0, 1'b0, 1'b0);
        check_frame("odd_stop0", 8'h01, exp_perr(8'h01, 2'b01, 1'b0), 1'b1);
        drive_bit(1'b1, BIT);

        // Glitch: 20 clocks low in IDLE is a false start
        drive_bit(1'b0, 20);
        check("glitch_active", 32'(active_flag), 32'd1);
        drive_bit(1'b1, 60);
        check("glitch_idle", 32'(active_flag), 32'd0);
        check("glitch_data", 32'(data_out), 32'h01);
        check("glitch_done", 32'(done_flag), 32'd1);
        check("glitch_ferr", 32'(frame_error), 32'd1);

        // Back-to-back frames with no idle gap
        parity_type = 2'b00;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        check("b2b_first_data", 32'(data_out), 32'h3C);
        check("b2b_first_done", 32'(done_flag), 32'd1);
        d = 8'hC3;
        drive_bit(1'b0, 10);
        check("b2b_done_low", 32'(done_flag), 32'd0);
        check("b2b_active", 32'(active_flag), 32'd1);
        drive_bit(1'b0, BIT - 10);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
        drive_bit(1'b1, BIT);
        check_frame("b2b_second", 8'hC3, 1'b0, 1'b0);

        // Reset in the middle of DATA, then a clean frame
        d = 8'h5A;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 3; i++) drive_bit(d[i], BIT);
        check("mid_active", 32'(active_flag), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_data", 32'(data_out), 32'h00);
        check("mid_rst_active", 32'(active_flag), 32'd0);
        check("mid_rst_done", 32'(done_flag), 32'd0);
        check("mid_rst_err", 32'({parity_error, frame_error}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        drive_bit(1'b1, 2 * BIT);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check_frame("post_rst", 8'h5A, 1'b0, 1'b0);

        // Random frames; config inputs scrambled mid-frame to exercise latching
        for (int n = 0; n < 10; n++) begin
            d    = 8'($urandom);
            pt   = 2'($urandom);
            pb   = 1'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            parity_type = pt;
            drive_bit(1'b1, BIT);
            send_frame(d, pb, stop, 1'b1);
            check_frame($sformatf("rnd%0d", n), d,
                        has_parity(pt) ? exp_perr(d, pt, pb) : 1'b0, ~stop);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
